sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO for the AXI FIFO subsystem, next generation of the FIFO driven through `write_enable` / `read_enable` / `read_data`. It adds:
- configurable width and depth
- an occupancy count
- programmable almost-full / almost-empty thresholds
- sticky overflow / underflow error flags
- a synchronous flush
- optional first-word-fall-through (FWFT) read mode

It sits between the AXI manager register path and downstream consumers.

## Interface
Parameters:
- `DATA_W`, 8, data width in bits (≥1)
- `DEPTH`, 16, number of entries; power of two, ≥4
- `AF_THRESH`, 14, `almost_full` asserts when count ≥ this value (1..DEPTH)
- `AE_THRESH`, 2, `almost_empty` asserts when count ≤ this value (0..DEPTH-1)
- `ADDR_W` is derived as `$clog2(DEPTH)` and is not overridable.

Ports:
- One clock; reset is synchronous and active-low.
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `flush`  in  1  synchronous empty-the-FIFO request
- `write_enable`  in  1  push request
- `write_data`  in  DATA_W  push data
- `read_enable`  in  1  pop request
- `read_data`  out  DATA_W  pop data
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `almost_full`  out  1  count ≥ AF_THRESH
- `almost_empty`  out  1  count ≤ AE_THRESH
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH
- `err_clr`  in  1  clears sticky error flags
- `overflow`  out  1  sticky: push attempted while full
- `underflow`  out  1  sticky: pop attempted while empty

## Operation
- Storage is a DEPTH×DATA_W register array, with ADDR_W-bit `wr_ptr` and `rd_ptr`. Pointers wrap DEPTH-1 → 0 by natural overflow.
- Accept rules:
  - `wr_acc` = `write_enable` & !`full`
  - `rd_acc` = `read_enable` & !`empty`
  - Both are evaluated on pre-edge flags.
  - No write-through-when-full and no read-through-when-empty.
- Count update: `count` += `wr_acc` − `rd_acc`. On simultaneous accept, count is unchanged and both pointers advance.
- Status outputs (`full`, `empty`, `almost_*`) decode directly from the `count` register, so they are glitch-free and free of combinational paths from inputs.
- Push at full: data is dropped, pointers and count are unchanged, `overflow` sets.
- Pop at empty: pointers and count are unchanged, `read_data` holds, `underflow` sets.
- Error flags:
  - Set on the edge following the offending request.
  - Cleared by `err_clr` on the next edge.
  - If a set condition and `err_clr` occur in the same cycle, set wins.
- Flush:
  - Sets pointers and count to 0 on the next edge.
  - Ignores `write_enable` / `read_enable` that cycle, with no error flags raised.
  - Does not clear `overflow` / `underflow`.
  - Does not clear `read_data` in standard mode.
- Reset priority: `rst_n` low > `flush` > normal operation.

## Timing
- Reset (`rst_n` low at a clock edge) values:
  - pointers = 0, `count` = 0
  - `empty` = 1, `full` = 0, `almost_empty` = 1, `almost_full` = 0
  - `overflow` = 0, `underflow` = 0, `read_data` = 0
- Memory contents are not reset. Reset mid-operation discards all stored data; the first post-reset pop returns the first post-reset push.
- Write-to-status latency: 1 cycle (`empty` falls on the edge that stores the first word).
- Standard mode: `read_data` is registered and updates on the edge of `rd_acc`, so it is valid 1 cycle after `read_enable`. It holds its value when there is no `rd_acc`.
- Minimum write-to-read-data latency: 2 cycles (push at edge N, pop request visible at edge N+1, data valid after edge N+1).
- Full throughput: one push and one pop per cycle sustained at any occupancy from 1 to DEPTH-1.

## Configuration
- Macro: `SYNC_FIFO_PARAM_FWFT_EN`.
- Defined (FWFT mode):
  - `read_data` = mem[`rd_ptr`] combinationally.
  - Head word is valid whenever `empty` = 0, i.e. 1 cycle after the first push.
  - `read_enable` acts as an acknowledge/pop; the next word appears in the same cycle the pop edge completes.
  - `read_data` is 0 when `empty` and after reset.
- Undefined (standard mode): registered read as described in Timing.
- Accept rules, flags, count, and error behaviour are identical in both modes.

## Test plan
All scenarios use DEPTH=16, DATA_W=8, AF=14, AE=2.
- Reset then idle → `empty`=1, `count`=0, `almost_empty`=1, `read_data`=0, errors=0.
- Push 0x01..0x10 (16 writes) → `almost_full` at count 14, `full` at 16. A 17th push (0xAA) → `overflow`=1, count stays 16. Then 16 pops return 0x01..0x10 in order, 1 cycle after each `read_enable` (standard mode).
- Pop when empty → `underflow`=1 and `read_data` unchanged. Assert `err_clr` → `underflow`=0 next cycle. Assert `err_clr` while popping empty → flag stays 1.
- Preload 8 words, then 70 cycles of simultaneous push/pop with random data → count stays 8 and output sequence equals input sequence delayed by 8 (covers pointer wrap).
- Preload 5 words, assert `flush` with `write_enable`=1 → next cycle count=0, `empty`=1, no `overflow`. The next push 0x5A is popped as 0x5A.
- FWFT build: a single push of 0x3C → `read_data`=0x3C one cycle later without `read_enable`. Pop → `empty`=1 and `read_data`=0.

Source files
------------

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//
// This is a parametrised single-clock FIFO that sits between the AXI manager
// register path and downstream consumers.
//
// Features:
//   - occupancy count
//   - almost-full / almost-empty thresholds
//   - sticky overflow / underflow flags
//   - synchronous flush
//
// Optional build macro:
//   SYNC_FIFO_PARAM_FWFT_EN
//     Defined   : first-word-fall-through. read_data shows the head word
//                 combinationally, and reads 0 while the FIFO is empty.
//     Undefined : standard mode. read_data is registered and updates on the
//                 edge that accepts a pop.
//
// Parameters:
//   DATA_W    : data width in bits
//   DEPTH     : number of entries (power of two, >= 4)
//   AF_THRESH : almost_full asserts when count >= AF_THRESH
//   AE_THRESH : almost_empty asserts when count <= AE_THRESH
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   flush        : synchronous empty request (ignores push/pop that cycle)
//   write_enable : push request
//   write_data   : push data
//   read_enable  : pop request
//   read_data    : pop data
//   full         : count == DEPTH
//   empty        : count == 0
//   almost_full  : count >= AF_THRESH
//   almost_empty : count <= AE_THRESH
//   count        : occupancy, 0..DEPTH
//   err_clr      : clears the sticky error flags
//   overflow     : sticky, a push was attempted while full
//   underflow    : sticky, a pop was attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_param #(
   parameter int  DATA_W    = 8,
   parameter int  DEPTH     = 16,
   parameter int  AF_THRESH = 14,
   parameter int  AE_THRESH = 2,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              write_enable,
   input  logic [DATA_W-1:0] write_data,
   input  logic              read_enable,
   output logic [DATA_W-1:0] read_data,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   input  logic              err_clr,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
   localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [ADDR_W:0]   count_reg, count_next;
   logic              overflow_reg, overflow_next;
   logic              underflow_reg, underflow_next;
   logic              wr_acc, rd_acc;

   // Status decodes only from the count register.
   // This keeps the flags glitch-free, with no combinational path from any input.
   assign full         = (count_reg == DEPTH_C);
   assign empty        = (count_reg == '0);
   assign almost_full  = (count_reg >= AF_C);
   assign almost_empty = (count_reg <= AE_C);
   assign count        = count_reg;
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

   // A flush cycle swallows both requests.
   assign wr_acc = write_enable & ~full  & ~flush;
   assign rd_acc = read_enable  & ~empty & ~flush;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
         if (wr_acc) wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
         if (rd_acc) rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
         count_next = count_reg + {{ADDR_W{1'b0}}, wr_acc}
                                - {{ADDR_W{1'b0}}, rd_acc};
      end
      // A new error event takes priority over err_clr in the same cycle.
      // A flush cycle never raises an error.
      overflow_next  = (write_enable & full  & ~flush) | (overflow_reg  & ~err_clr);
      underflow_next = (read_enable  & empty & ~flush) | (underflow_reg & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         count_reg     <= count_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (rst_n && wr_acc) mem[wr_ptr_reg] <= write_data;
   end

`ifdef SYNC_FIFO_PARAM_FWFT_EN
   // The head word is visible combinationally and is forced to 0 while empty.
   assign read_data = empty ? '0 : mem[rd_ptr_reg];
`else
   logic [DATA_W-1:0] rdata_reg;

   // read_data holds between accepted pops, including across a flush.
   always_ff @(posedge clk) begin
      if (!rst_n)
         rdata_reg <= '0;
      else if (rd_acc)
         rdata_reg <= mem[rd_ptr_reg];
   end

   assign read_data = rdata_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst_n, flush, we, re, ec;
   logic [DW-1:0] wd;
   logic [DW-1:0] read_data;
   logic          full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0]    count;

   sync_fifo_param #(
      .DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .write_enable(we), .write_data(wd),
      .read_enable(re), .read_data(read_data),
      .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .err_clr(ec),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   bit checking    = 1'b0;

   // Reference model: a queue holding the FIFO contents, plus the sticky
   // flags and the last popped word.
   logic [DW-1:0] mq[$];
   bit            m_ovf = 1'b0;
   bit            m_udf = 1'b0;
   logic [DW-1:0] m_rd  = '0;

   function automatic void chk(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int exp_rd();
`ifdef SYNC_FIFO_PARAM_FWFT_EN
      return (mq.size() == 0) ? 0 : int'(mq[0]);
`else
      return int'(m_rd);
`endif
   endfunction

   // Model update on every rising edge, using the pre-edge occupancy.
   always @(posedge clk) begin
      int n;
      bit ovf_set, udf_set;
      n = mq.size();
      if (!rst_n) begin
         mq.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         m_rd  = '0;
      end else begin
         ovf_set = !flush && we && (n == DEPTH);
         udf_set = !flush && re && (n == 0);
         if (flush) begin
            mq.delete();
         end else begin
            if (re && n > 0)     m_rd = mq.pop_front();
            if (we && n < DEPTH) mq.push_back(wd);
         end
         m_ovf = ovf_set || (m_ovf && !ec);
         m_udf = udf_set || (m_udf && !ec);
      end
   end

   // One compare process, sampling away from the active edge.
   always @(negedge clk) begin
      if (checking) begin
         chk("count",        int'(count),        mq.size());
         chk("full",         int'(full),         int'(mq.size() == DEPTH));
         chk("empty",        int'(empty),        int'(mq.size() == 0));
         chk("almost_full",  int'(almost_full),  int'(mq.size() >= AF));
         chk("almost_empty", int'(almost_empty), int'(mq.size() <= AE));
         chk("overflow",     int'(overflow),     int'(m_ovf));
         chk("underflow",    int'(underflow),    int'(m_udf));
         chk("read_data",    int'(read_data),    exp_rd());
      end
   end

   task automatic drive(bit r_n, bit fl, bit w, logic [DW-1:0] d, bit r, bit c);
      rst_n = r_n;
      flush = fl;
      we    = w;
      wd    = d;
      re    = r;
      ec    = c;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [DW-1:0] hq[$];
      logic [DW-1:0] d;
      int wprob, rprob;

      // Reset, then idle.
      drive(0, 0, 0, 8'h00, 0, 0);
      drive(0, 0, 0, 8'h00, 0, 0);
      checking = 1'b1;
      drive(1, 0, 0, 8'h00, 0, 0);
      chk("rst_count",     int'(count),        0);
      chk("rst_empty",     int'(empty),        1);
      chk("rst_ae",        int'(almost_empty), 1);
      chk("rst_rdata",     int'(read_data),    0);
      chk("rst_ovf",       int'(overflow),     0);
      chk("rst_udf",       int'(underflow),    0);
      $display("reset: count=%0d empty=%0b", count, empty);

      // Fill to full.
      for (int i = 1; i <= 16; i++) begin
         drive(1, 0, 1, 8'(i), 0, 0);
         chk("fill_count", int'(count), i);
         $display("push 0x%02h: count=%0d af=%0b full=%0b", i, count, almost_full, full);
      end
      chk("af_at_16", int'(almost_full), 1);
      chk("full_16",  int'(full),        1);

      // 17th push overflows.
      drive(1, 0, 1, 8'hAA, 0, 0);
      chk("ovf_set",   int'(overflow), 1);
      chk("ovf_count", int'(count),    16);
      $display("push 0xaa at full: overflow=%0b count=%0d", overflow, count);

      drive(1, 0, 0, 8'h00, 0, 1);
      chk("ovf_clr", int'(overflow), 0);
      $display("err_clr: overflow=%0b", overflow);

      // Drain in order.
      for (int i = 1; i <= 16; i++) begin
`ifdef SYNC_FIFO_PARAM_FWFT_EN
         chk("drain_data", int'(read_data), i);
         drive(1, 0, 0, 8'h00, 1, 0);
`else
         drive(1, 0, 0, 8'h00, 1, 0);
         chk("drain_data", int'(read_data), i);
`endif
         $display("pop: read_data=0x%02h count=%0d", read_data, count);
      end

      // Underflow behaviour.
      drive(1, 0, 0, 8'h00, 1, 0);
      chk("udf_set", int'(underflow), 1);
`ifdef SYNC_FIFO_PARAM_FWFT_EN
      chk("udf_rdata", int'(read_data), 0);
`else
      chk("udf_rdata", int'(read_data), 16);
`endif
      $display("pop at empty: underflow=%0b read_data=0x%02h", underflow, read_data);

      drive(1, 0, 0, 8'h00, 0, 1);
      chk("udf_clr", int'(underflow), 0);
      $display("err_clr: underflow=%0b", underflow);

      drive(1, 0, 0, 8'h00, 1, 1);
      chk("udf_set_wins", int'(underflow), 1);
      $display("err_clr+pop at empty: underflow=%0b", underflow);

      drive(1, 0, 0, 8'h00, 0, 1);

      // Preload 8, then streaming push/pop across the pointer wrap.
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom);
         hq.push_back(d);
         drive(1, 0, 1, d, 0, 0);
      end
      for (int k = 0; k < 70; k++) begin
         d = 8'($urandom);
         hq.push_back(d);
`ifdef SYNC_FIFO_PARAM_FWFT_EN
         chk("stream_data", int'(read_data), int'(hq.pop_front()));
         drive(1, 0, 1, d, 1, 0);
`else
         drive(1, 0, 1, d, 1, 0);
         chk("stream_data", int'(read_data), int'(hq.pop_front()));
`endif
         chk("stream_count", int'(count), 8);
         $display("stream %0d: in=0x%02h out=0x%02h count=%0d", k, d, read_data, count);
      end
      while (hq.size() > 0) begin
`ifdef SYNC_FIFO_PARAM_FWFT_EN
         chk("stream_tail", int'(read_data), int'(hq.pop_front()));
         drive(1, 0, 0, 8'h00, 1, 0);
`else
         drive(1, 0, 0, 8'h00, 1, 0);
         chk("stream_tail", int'(read_data), int'(hq.pop_front()));
`endif
      end

      // Flush with write_enable high.
      for (int i = 0; i < 5; i++) drive(1, 0, 1, 8'(8'h20 + i), 0, 0);
      drive(1, 1, 1, 8'h77, 0, 0);
      chk("flush_count", int'(count),    0);
      chk("flush_empty", int'(empty),    1);
      chk("flush_ovf",   int'(overflow), 0);
      $display("flush: count=%0d empty=%0b overflow=%0b", count, empty, overflow);

      drive(1, 0, 1, 8'h5A, 0, 0);
`ifdef SYNC_FIFO_PARAM_FWFT_EN
      chk("post_flush", int'(read_data), 8'h5A);
      drive(1, 0, 0, 8'h00, 1, 0);
`else
      drive(1, 0, 0, 8'h00, 1, 0);
      chk("post_flush", int'(read_data), 8'h5A);
`endif
      $display("post-flush pop: read_data=0x%02h", read_data);

`ifdef SYNC_FIFO_PARAM_FWFT_EN
      drive(1, 0, 1, 8'h3C, 0, 0);
      chk("fwft_head", int'(read_data), 8'h3C);
      drive(1, 0, 0, 8'h00, 1, 0);
      chk("fwft_empty", int'(empty),     1);
      chk("fwft_zero",  int'(read_data), 0);
      $display("fwft: empty=%0b read_data=0x%02h", empty, read_data);
`endif

      // Random phase; push/pop bias changes every 200 cycles so the FIFO
      // visits both full and empty.
      wprob = 50;
      rprob = 50;
      for (int k = 0; k < 3000; k++) begin
         if (k % 200 == 0) begin
            wprob = $urandom_range(10, 90);
            rprob = $urandom_range(10, 90);
         end
         drive($urandom_range(0, 299) != 0,
               $urandom_range(0, 59) == 0,
               $urandom_range(0, 99) < wprob,
               8'($urandom),
               $urandom_range(0, 99) < rprob,
               $urandom_range(0, 24) == 0);
         $display("rand %0d: count=%0d rd=0x%02h ovf=%0b udf=%0b", k, count, read_data,
                  overflow, underflow);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
